uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between NUM_REQ byte producers. Round-robin arbitration.
//  Sequences each frame through the transmitter's transmit/TxData/busy handshake,
//  with an enforced inter-frame gap and a start-acknowledge timeout.
//  Sits between the producer blocks and the UART TX (the DUT's transmit/TxData inputs).
// PARAMETERS
//  NUM_REQ      4   number of requesters (>=2)
//  DATA_W       8   frame data width
//  GAP_CYCLES   2   idle clks enforced after tx_busy falls (0 allowed)
//  ACK_TIMEOUT  16  clks allowed in START for tx_busy to rise
// PORTS
//  clk          in   1                 system clock, rising edge
//  reset        in   1                 synchronous, active-high
//  req_valid    in   NUM_REQ           per-requester byte valid
//  req_data     in   NUM_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ           one-cycle accept pulse; transfer = valid & ready
//  transmit     out  1                 start request to UART TX
//  TxData       out  DATA_W            byte to UART TX
//  tx_busy      in   1                 UART TX frame in progress
//  grant_id     out  $clog2(NUM_REQ)   index of the last accepted requester
//  err_timeout  out  1                 one-cycle pulse: tx_busy never rose
// BEHAVIOUR
//  Reset: transmit=0, TxData=0, req_ready=0, grant_id=0, err_timeout=0, state=IDLE,
//   rr pointer=0 (requester 0 highest priority). Mid-frame reset abandons the frame
//   and takes effect on the next edge; it ignores tx_busy.
//  All outputs are registered. States: IDLE, START, BUSY, GAP.
//  IDLE: at an edge with any req_valid set, pick the first set bit scanning from ptr
//   upward, modulo NUM_REQ. Next cycle: req_ready[i]=1 (exactly one cycle),
//   TxData=req_data[i], transmit=1, grant_id=i, ptr=(i+1)%NUM_REQ, state=START.
//   Latency: one cycle from sampled req_valid to req_ready.
//  Requester rule: hold req_valid and data stable until req_ready. Deasserting earlier
//   is illegal. A requester that drops req_valid before the grant edge is not granted.
//  START: transmit is held at 1. Timer counts clks in START.
//   - tx_busy==1 sampled: transmit=0 next cycle, state=BUSY.
//   - ACK_TIMEOUT clks without tx_busy: transmit=0, err_timeout=1 for one cycle,
//     state=GAP.
//   - tx_busy wins if both conditions occur on the same edge.
//  BUSY: wait for tx_busy==0 sampled, then state=GAP.
//  GAP: stay GAP_CYCLES clks, then IDLE. If GAP_CYCLES==0, go BUSY->IDLE directly.
//   Next transmit rises no earlier than GAP_CYCLES+2 edges after tx_busy is sampled 0.
//  TxData and grant_id stay stable from accept until the next accept.
//  req_valid is ignored outside IDLE. req_ready is 0 in all states except the accept cycle.
//  At most one req_ready bit is set at any time. The ptr wraps from NUM_REQ-1 to 0.
//  The same requester may be re-granted back-to-back if no other req_valid is set.
// TESTING
//  T1 single: req_valid=4'b0100, data2=8'hA5 -> next clk req_ready=4'b0100,
//     TxData=A5, grant_id=2, transmit=1; tx_busy=1 -> transmit=0 next clk.
//  T2 fairness: req_valid=4'b1111 held, model UART busy 10 clks/frame
//     -> grant order 0,1,2,3,0,1; no double req_ready.
//  T3 timeout: tx_busy tied 0 -> err_timeout pulse after 16 clks in START,
//     transmit=0; after GAP, the next requester is granted.
//  T4 reset mid-BUSY: reset=1 for 1 clk -> all outputs 0 next edge;
//     with 4'b1010 valid after reset, requester 1 is granted first.
//  T5 gap: GAP_CYCLES=2, tx_busy falls at edge t, another req pending
//     -> transmit rises exactly at edge t+4, not earlier.
//  T6 repeat: only req 3 valid for 3 frames -> grant_id=3 each frame; ptr wrap ok.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Sequences each frame through transmit/TxData/tx_busy with an inter-frame gap and ack timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       transmit,
  output logic [DATA_W-1:0]          TxData,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam state_t POST_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ID_W-1:0]     ptr, ptr_d;
  logic [NUM_REQ-1:0]  ready_d;
  logic                transmit_d;
  logic [DATA_W-1:0]   txdata_d;
  logic [ID_W-1:0]     grant_d;
  logic                err_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W:0]       cand;
  logic [DATA_W-1:0]   pick_data;

  // Rotating-priority search: first set req_valid bit at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!pick_found && req_valid[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign pick_data = req_data[pick_idx*DATA_W +: DATA_W];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave it unassigned (no latch).
    state_d    = state;
    cnt_d      = cnt;
    ptr_d      = ptr;
    ready_d    = '0;
    transmit_d = transmit;
    txdata_d   = TxData;
    grant_d    = grant_id;
    err_d      = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          ready_d    = NUM_REQ'(1) << pick_idx;
          transmit_d = 1'b1;
          txdata_d   = pick_data;
          grant_d    = pick_idx;
          ptr_d      = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
          cnt_d      = '0;
          state_d    = START;
        end
      end

      START: begin
        // An acknowledge on the same edge as the timeout takes precedence.
        if (tx_busy) begin
          transmit_d = 1'b0;
          state_d    = BUSY;
        end else if (cnt == ACK_LAST) begin
          transmit_d = 1'b0;
          err_d      = 1'b1;
          cnt_d      = '0;
          state_d    = POST_FRAME;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      BUSY: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = POST_FRAME;
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) state_d = IDLE;
        else                 cnt_d   = cnt + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      req_ready   <= '0;
      transmit    <= 1'b0;
      TxData      <= '0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      ptr         <= ptr_d;
      req_ready   <= ready_d;
      transmit    <= transmit_d;
      TxData      <= txdata_d;
      grant_id    <= grant_d;
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: timeline reference model, per-cycle compare,
// directed scenarios with hand-computed expectations, then randomized producers and UART.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int GAP_CYCLES  = 2;
  localparam int ACK_TIMEOUT = 16;
  // Edges from the deciding edge (busy sampled low / timeout) to the next possible accept.
  localparam int GAP_SPAN    = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES + 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      transmit;
  logic [DATA_W-1:0]         TxData;
  logic                      tx_busy = 1'b0;
  logic [1:0]                grant_id;
  logic                      err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .transmit(transmit), .TxData(TxData), .tx_busy(tx_busy),
    .grant_id(grant_id), .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: frame timeline ----------------
  int               cyc = 0;
  bit               m_in_frame = 1'b0;
  bit               m_wait_ack = 1'b0;
  int               m_start = 0;
  int               m_next_free = 0;
  int               m_ptr = 0;
  int               m_w;
  logic [3:0]       e_ready = '0;
  logic             e_tx = 1'b0;
  logic [7:0]       e_data = '0;
  logic [1:0]       e_grant = '0;
  logic             e_err = 1'b0;

  always @(posedge clk) begin
    cyc++;
    e_ready = '0;
    e_err   = 1'b0;
    if (reset) begin
      m_in_frame  = 1'b0;
      m_wait_ack  = 1'b0;
      m_ptr       = 0;
      m_next_free = cyc + 1;
      e_tx        = 1'b0;
      e_data      = '0;
      e_grant     = '0;
    end else if (!m_in_frame) begin
      if (cyc >= m_next_free && req_valid != '0) begin
        m_w = -1;
        for (int k = 0; k < NUM_REQ; k++)
          if (m_w < 0 && req_valid[(m_ptr + k) % NUM_REQ]) m_w = (m_ptr + k) % NUM_REQ;
        e_ready[m_w] = 1'b1;
        e_tx         = 1'b1;
        e_data       = req_data[m_w*DATA_W +: DATA_W];
        e_grant      = 2'(m_w);
        m_ptr        = (m_w + 1) % NUM_REQ;
        m_in_frame   = 1'b1;
        m_wait_ack   = 1'b1;
        m_start      = cyc;
      end
    end else if (m_wait_ack) begin
      if (tx_busy) begin
        e_tx       = 1'b0;
        m_wait_ack = 1'b0;
      end else if (cyc - m_start == ACK_TIMEOUT) begin
        e_tx        = 1'b0;
        e_err       = 1'b1;
        m_wait_ack  = 1'b0;
        m_in_frame  = 1'b0;
        m_next_free = cyc + GAP_SPAN;
      end
    end else if (!tx_busy) begin
      m_in_frame  = 1'b0;
      m_next_free = cyc + GAP_SPAN;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("req_ready",   32'(req_ready),   32'(e_ready));
      check("transmit",    32'(transmit),    32'(e_tx));
      check("TxData",      32'(TxData),      32'(e_data));
      check("grant_id",    32'(grant_id),    32'(e_grant));
      check("err_timeout", 32'(err_timeout), 32'(e_err));
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    end
  end

  // ---------------- UART transmitter model ----------------
  typedef enum int { U_AUTO, U_FIXED, U_NEVER } umode_t;
  umode_t umode = U_FIXED;
  int     u_fixed_len = 3;
  int     u_phase = 0;
  int     u_cnt = 0;
  int     u_fall_edge = 0;

  always @(negedge clk) begin
    if (u_phase == 0 && transmit) begin
      if (umode == U_NEVER || (umode == U_AUTO && $urandom_range(0, 15) == 0)) begin
        u_phase = 3;
      end else begin
        u_phase = 1;
        u_cnt   = (umode == U_AUTO) ? int'($urandom_range(0, 3)) : 0;
      end
    end
    if (u_phase == 1) begin
      if (u_cnt == 0) begin
        tx_busy = 1'b1;
        u_phase = 2;
        u_cnt   = (umode == U_AUTO) ? int'($urandom_range(1, 12)) : u_fixed_len;
      end else begin
        u_cnt--;
      end
    end else if (u_phase == 2) begin
      u_cnt--;
      if (u_cnt == 0) begin
        tx_busy     = 1'b0;
        u_phase     = 0;
        u_fall_edge = cyc + 1;
      end
    end else if (u_phase == 3) begin
      if (!transmit) u_phase = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int edge_no, input string name);
    bit seen = 1'b0;
    edge_no = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (req_ready != '0) begin
        seen    = 1'b1;
        edge_no = cyc;
      end
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  int t2_order[6] = '{0, 1, 2, 3, 0, 1};
  int a_edge, b_edge, err_edge;
  bit found;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_tx",    32'(transmit),  32'd0);
    check("rst_data",  32'(TxData),    32'd0);
    check("rst_grant", 32'(grant_id),  32'd0);
    check("rst_err",   32'(err_timeout), 32'd0);
    reset = 1'b0;
    tick();

    // T1: single requester, one-cycle accept latency, transmit drops after busy.
    req_data[2*DATA_W +: DATA_W] = 8'hA5;
    req_valid = 4'b0100;
    tick();
    check("t1_ready", 32'(req_ready), 32'h4);
    check("t1_data",  32'(TxData),    32'hA5);
    check("t1_grant", 32'(grant_id),  32'd2);
    check("t1_tx",    32'(transmit),  32'd1);
    req_valid = '0;
    tick();
    check("t1_tx_drop",    32'(transmit),  32'd0);
    check("t1_ready_drop", 32'(req_ready), 32'd0);
    repeat (12) tick();

    // T2: all requesters held, fixed 10-cycle frames -> strict rotation.
    do_reset();
    u_fixed_len = 10;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 8'($urandom);
    req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      wait_ready(a_edge, "t2_wait");
      check("t2_order", 32'(grant_id), 32'(t2_order[g]));
      req_data[int'(grant_id)*DATA_W +: DATA_W] = 8'($urandom);
    end
    req_valid = '0;
    repeat (20) tick();

    // T3: no acknowledge -> timeout pulse 16 edges after accept, next requester after the gap.
    umode = U_NEVER;
    do_reset();
    tick();
    req_valid = 4'b0001;
    wait_ready(a_edge, "t3_wait_a");
    req_valid = 4'b0011;
    found = 1'b0;
    err_edge = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (err_timeout) begin
        found    = 1'b1;
        err_edge = cyc;
        check("t3_tx_low", 32'(transmit), 32'd0);
      end
    end
    check("t3_seen", 32'(found), 32'd1);
    check("t3_latency", 32'(err_edge - a_edge), 32'd16);
    wait_ready(b_edge, "t3_wait_b");
    check("t3_next_grant", 32'(grant_id), 32'd1);
    check("t3_regrant_gap", 32'(b_edge - err_edge), 32'd4);
    req_valid = '0;
    repeat (30) tick();

    // T4: reset in BUSY clears outputs and the pointer.
    umode = U_FIXED;
    u_fixed_len = 10;
    repeat (3) tick();
    do_reset();
    req_valid = 4'b0100;
    wait_ready(a_edge, "t4_wait_a");
    req_valid = '0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (tx_busy && !transmit) found = 1'b1;
    end
    check("t4_in_busy", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    check("t4_ready", 32'(req_ready),   32'd0);
    check("t4_tx",    32'(transmit),    32'd0);
    check("t4_data",  32'(TxData),      32'd0);
    check("t4_grant", 32'(grant_id),    32'd0);
    check("t4_err",   32'(err_timeout), 32'd0);
    reset = 1'b0;
    req_valid = 4'b1010;
    wait_ready(a_edge, "t4_wait_b");
    check("t4_first_grant", 32'(grant_id), 32'd1);
    check("t4_first_ready", 32'(req_ready), 32'h2);

    // T6: only requester 3 -> re-granted every frame, pointer wraps.
    req_valid = 4'b1000;
    for (int g = 0; g < 3; g++) begin
      wait_ready(a_edge, "t6_wait");
      check("t6_grant", 32'(grant_id), 32'd3);
    end
    req_valid = '0;
    repeat (20) tick();

    // T5: a pending request is accepted exactly 4 edges after busy is sampled low.
    u_fixed_len = 5;
    req_valid = 4'b0011;
    wait_ready(a_edge, "t5_wait_a");
    check("t5_first", 32'(grant_id), 32'd0);
    wait_ready(b_edge, "t5_wait_b");
    check("t5_second", 32'(grant_id), 32'd1);
    check("t5_gap", 32'(b_edge - u_fall_edge), 32'd4);
    req_valid = '0;
    repeat (20) tick();

    // Randomized producers, UART delays, occasional missing acks and resets.
    umode = U_AUTO;
    repeat (2) tick();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0;
          req_data[i*DATA_W +: DATA_W] = 8'($urandom);
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = 8'($urandom);
        end
      end
    end
    reset = 1'b0;
    req_valid = '0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
